// File: rtl/xm_pkg.sv
// Shared types and constants for the X-Makina memory responder.
// Byte lane numbering is little-endian: address bit 0 selects the lane.
package xm_pkg;

  localparam int DEFAULT_WORD = 16;
  localparam int LANE_LO      = 0;
  localparam int LANE_HI      = 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    ACK
  } mem_state_t;

endpackage

// File: rtl/xm_mem_array.sv
// Single-port word RAM with per-byte write enables and a one-cycle registered read.
// Contents are not reset.
module xm_mem_array
  import xm_pkg::*;
#(
  parameter int WORD  = DEFAULT_WORD,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [WORD/8-1:0]        be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WORD-1:0]          wdata_i,
  output logic [WORD-1:0]          rdata_o
);

  logic [WORD-1:0] mem_q [DEPTH];
  logic [WORD-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < WORD / 8; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/xm_mem_responder.sv
// Memory-side responder: accepts a request, inserts wait states, performs a byte/word
// RAM access and returns a one-cycle ack with read data and an error flag.
module xm_mem_responder
  import xm_pkg::*;
#(
  parameter int WORD        = DEFAULT_WORD,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            wr_i,
  input  logic            byte_i,
  input  logic [WORD-1:0] addr_i,
  input  logic [WORD-1:0] wdata_i,
  output logic [WORD-1:0] rdata_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam int NB = WORD / 8;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 4;
  localparam logic [WORD:0] BYTE_LIMIT = (WORD + 1)'(2 * DEPTH_WORDS);

  mem_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q;
  logic            lane_q, wr_q, byte_q, err_q;
  logic [WORD-1:0] wdata_q, rdata_q;

  logic            req_err;
  logic            ram_en, ram_we;
  logic [NB-1:0]   be;
  logic [WORD-1:0] ram_wdata, ram_rdata, rdata_fmt;
  logic [7:0]      lane_byte [NB];

  assign req_err = ({1'b0, addr_i} >= BYTE_LIMIT) || (!byte_i && addr_i[0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          cnt_d   = CW'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ACCESS;
      end
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write in ACCESS commits even if rst_i is high that cycle; only the FSM is reset.
  always_comb begin
    ram_en  = (state_q == ACCESS) && !err_q;
    ram_we  = ram_en && wr_q;
    ack_o   = (state_q == ACK) && !rst_i;
    err_o   = ack_o && err_q;
    busy_o  = (state_q != IDLE);
    rdata_o = (state_q == ACK) ? rdata_fmt : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= 1'b0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == IDLE && req_i) begin
        idx_q   <= addr_i[AW:1];
        lane_q  <= addr_i[0];
        wr_q    <= wr_i;
        byte_q  <= byte_i;
        err_q   <= req_err;
        wdata_q <= wdata_i;
      end
      if (state_q == ACK) rdata_q <= rdata_fmt;
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign be[gi]        = !byte_q || (lane_q ? (gi == LANE_HI) : (gi == LANE_LO));
    assign lane_byte[gi] = ram_rdata[gi*8 +: 8];
  end

  // Byte writes replicate the low byte so the enabled lane picks it up.
  assign ram_wdata = byte_q ? {NB{wdata_q[7:0]}} : wdata_q;

  always_comb begin
    rdata_fmt = '0;
    if (!err_q && !wr_q) begin
      if (byte_q) rdata_fmt[7:0] = lane_q ? lane_byte[LANE_HI] : lane_byte[LANE_LO];
      else        rdata_fmt      = ram_rdata;
    end
  end

  xm_mem_array #(
    .WORD  (WORD),
    .DEPTH (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (be),
    .addr_i  (idx_q),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_xm_mem_responder.sv
// Scoreboard bench for xm_mem_responder: a reference memory model predicts each ack,
// and a negedge monitor compares every ack against the queued prediction.
module tb_xm_mem_responder;

  localparam int WS = 2;
  localparam int DW = 1024;

  typedef struct {
    int          id;
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, wr, byt;
  logic [15:0] addr, wdata, rdata;
  logic        ack, err, busy;

  logic        req0, wr0, byt0;
  logic [15:0] addr0, wdata0, rdata0;
  logic        ack0, err0, busy0;

  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          txn_id = 0;
  exp_t        sb[$];
  logic [15:0] mem_m [DW];
  logic [15:0] last_rd = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  xm_mem_responder #(.WORD(16), .DEPTH_WORDS(DW), .WAIT_STATES(WS)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wr_i(wr), .byte_i(byt),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
    .ack_o(ack), .err_o(err), .busy_o(busy)
  );

  xm_mem_responder #(.WORD(16), .DEPTH_WORDS(DW), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .wr_i(wr0), .byte_i(byt0),
    .addr_i(addr0), .wdata_i(wdata0), .rdata_o(rdata0),
    .ack_o(ack0), .err_o(err0), .busy_o(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Reference model: compute the expected response from the access rules, update memory.
  task automatic txn(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    exp_t        e;
    int          n;
    logic [9:0]  idx;
    e.id    = txn_id++;
    e.err   = (a >= 16'(2 * DW)) || (!b && a[0]);
    e.rdata = 16'h0;
    idx     = a[10:1];
    if (!e.err) begin
      if (w) begin
        if (!b)       mem_m[idx]       = d;
        else if (a[0]) mem_m[idx][15:8] = d[7:0];
        else          mem_m[idx][7:0]  = d[7:0];
      end else if (b) begin
        e.rdata = a[0] ? {8'h00, mem_m[idx][15:8]} : {8'h00, mem_m[idx][7:0]};
      end else begin
        e.rdata = mem_m[idx];
      end
    end
    @(posedge clk); #1;
    wr = w; byt = b; addr = a; wdata = d; req = 1'b1;
    e.cyc = cyc + WS + 2;
    sb.push_back(e);
    $display("txn %0d: %s %s addr=%h wdata=%h exp_rdata=%h exp_err=%0b",
             e.id, w ? "WR" : "RD", b ? "B" : "W", a, d, e.rdata, e.err);
    // Latched inputs must be ignored once the request is accepted.
    @(posedge clk); #1;
    addr = 16'($urandom); wdata = 16'($urandom); wr = 1'($urandom); byt = 1'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    if (!ack) begin
      checks++;
      $display("FAIL ack_timeout txn %0d: no ack within %0d cycles", e.id, n);
    end
    req = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every ack; between acks rdata_o must hold and err_o stay low.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rd = 16'h0;
      end else if (ack) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_ack: rdata=%h err=%0b with empty scoreboard", rdata, err);
        end else begin
          e = sb.pop_front();
          chk($sformatf("rdata txn%0d", e.id), 32'(rdata), 32'(e.rdata));
          chk($sformatf("err txn%0d", e.id), 32'(err), 32'(e.err));
          chk($sformatf("latency txn%0d", e.id), 32'(cyc), 32'(e.cyc));
          last_rd = e.rdata;
        end
      end else begin
        chk("rdata_hold", 32'(rdata), 32'(last_rd));
        chk("err_idle", 32'(err), 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a1, a2, lowb, n, r;
    logic [15:0] ra;
    rst = 1'b1; req = 1'b0; wr = 1'b0; byt = 1'b0; addr = 16'h0; wdata = 16'h0;
    req0 = 1'b0; wr0 = 1'b0; byt0 = 1'b0; addr0 = 16'h0; wdata0 = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_busy0", 32'(busy0), 32'h0);

    // Known contents for every word the random phase will touch.
    for (int i = 0; i < 32; i++) txn(1'b1, 1'b0, 16'(2 * i), 16'($urandom));
    for (int i = DW - 8; i < DW; i++) txn(1'b1, 1'b0, 16'(2 * i), 16'($urandom));

    txn(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    txn(1'b0, 1'b0, 16'h0010, 16'h0000);
    txn(1'b1, 1'b1, 16'h0011, 16'h005A);
    txn(1'b0, 1'b0, 16'h0010, 16'h0000);
    txn(1'b0, 1'b1, 16'h0010, 16'h0000);
    txn(1'b0, 1'b1, 16'h0011, 16'h0000);
    txn(1'b0, 1'b0, 16'h0013, 16'h0000);
    txn(1'b0, 1'b0, 16'h0012, 16'h0000);
    txn(1'b1, 1'b0, 16'h0800, 16'h1111);
    txn(1'b1, 1'b0, 16'h07FE, 16'hC0DE);
    txn(1'b0, 1'b0, 16'h07FE, 16'h0000);
    txn(1'b0, 1'b1, 16'h0801, 16'h0000);
    txn(1'b1, 1'b1, 16'hFFFF, 16'h0077);

    // Reset during WAIT of a write: no ack, no RAM change.
    @(posedge clk); #1;
    wr = 1'b1; byt = 1'b0; addr = 16'h0020; wdata = 16'h1234; req = 1'b1;
    @(posedge clk); #1;
    chk("busy_in_wait", 32'(busy), 32'h1);
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("busy_after_rst", 32'(busy), 32'h0);
    repeat (6) @(posedge clk);
    txn(1'b0, 1'b0, 16'h0020, 16'h0000);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      ra = 16'($urandom_range(0, 63));
      else if (r < 9) ra = 16'($urandom_range(2032, 2047));
      else            ra = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(2048, 2100)) : 16'hFFFF;
      txn(1'($urandom), 1'($urandom), ra, 16'($urandom));
    end

    // Zero wait states, request held across the ack: two back-to-back transactions.
    @(posedge clk); #1;
    wr0 = 1'b1; byt0 = 1'b0; addr0 = 16'h0004; wdata0 = 16'hA5A5; req0 = 1'b1;
    s = cyc; a1 = -1; a2 = -1; lowb = 0;
    for (int i = 0; i < 20 && a2 < 0; i++) begin
      @(negedge clk);
      if (ack0) begin
        if (a1 < 0) a1 = cyc;
        else begin
          a2 = cyc;
          req0 = 1'b0;
        end
      end else if (a1 >= 0 && !busy0) begin
        lowb++;
      end
    end
    req0 = 1'b0;
    $display("b2b: first ack cycle %0d, second ack cycle %0d, idle gap %0d", a1 - s, a2 - a1, lowb);
    chk("b2b_first_latency", 32'(a1 - s), 32'd2);
    chk("b2b_spacing", 32'(a2 - a1), 32'd3);
    chk("b2b_busy_gap", 32'(lowb), 32'd1);
    @(posedge clk); #1;
    wr0 = 1'b0; req0 = 1'b1; s = cyc; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack0 && n < 10);
    req0 = 1'b0;
    $display("ws0 read: rdata=%h err=%0b after %0d cycles", rdata0, err0, cyc - s);
    chk("ws0_rd_ack", 32'(ack0), 32'h1);
    chk("ws0_rd_latency", 32'(cyc - s), 32'd2);
    chk("ws0_rd_data", 32'(rdata0), 32'h0000A5A5);
    chk("ws0_rd_err", 32'(err0), 32'h0);

    repeat (8) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
